exc_vector_fetch: RTL and testbench

- Multi-cycle exception sequencer for the MIPS datapath.
- On an exception cause it does five things:
  - saves EPC;
  - drives the memory-address mux select to one of the fixed vector addresses 253/254/255;
  - waits out memory read latency;
  - captures the handler byte;
  - commits it, zero-extended, to PC.
- It produces the IorD select codes 001/010/011 that the address mux consumes, and it consumes the memory read data that comes back.

---
 rtl/exc_vector_fetch.sv | 183 ++++++++++++++++++
 tb/tb_exc_vector_fetch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_vector_fetch.sv
// ---------------------------------------------------------------------------
// exc_vector_fetch
// Multi-cycle exception sequencer. When an exception cause is sampled in
// IDLE it does the following:
//   - saves EPC (pc_current - PC_ADJUST);
//   - points the memory address mux at vector 253/254/255;
//   - waits MEM_LAT cycles for the read data;
//   - captures the handler byte;
//   - commits it, zero-extended, to PC.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   exc_opcode   in   invalid-opcode request (level, highest priority)
//   exc_overflow in   overflow request (level)
//   exc_divzero  in   divide-by-zero request (level, lowest priority)
//   pc_current   in   current PC register value
//   mem_rdata    in   memory read data, handler address in [7:0]
//   iord_sel     out  address mux select: 000 PC, 001/010/011 vectors
//   epc_wr       out  EPC write strobe
//   epc_value    out  value for EPC
//   pc_wr        out  PC write strobe
//   pc_value     out  handler address, zero-extended
//   cause        out  latched cause: 00 none, 01 opcode, 10 ovf, 11 divzero
//   busy         out  sequence in progress
//   exc_lost     out  sticky: a request arrived while not idle
// ---------------------------------------------------------------------------
module exc_vector_fetch #(
    parameter int unsigned MEM_LAT   = 2,
    parameter logic [31:0] PC_ADJUST = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] pc_current,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  iord_sel,
    output logic        epc_wr,
    output logic [31:0] epc_value,
    output logic        pc_wr,
    output logic [31:0] pc_value,
    output logic [1:0]  cause,
    output logic        busy,
    output logic        exc_lost
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned ST_W  = 2;

    localparam logic [ST_W-1:0] S_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] S_FETCH   = 2'd1;
    localparam logic [ST_W-1:0] S_CAPTURE = 2'd2;
    localparam logic [ST_W-1:0] S_COMMIT  = 2'd3;

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ST_W-1:0]  state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [1:0]       cause_q,    cause_d;
    logic [31:0]      epc_q,      epc_d;
    logic [31:0]      pcv_q,      pcv_d;
    logic [2:0]       iord_q,     iord_d;
    logic             epc_wr_q,   epc_wr_d;
    logic             pc_wr_q,    pc_wr_d;
    logic             busy_q,     busy_d;
    logic             lost_q,     lost_d;

    logic             req_any_c;
    logic [1:0]       req_code_c;

    // Only the low byte of the read data carries the handler address.
    logic             unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[31:8];

    // Fixed-priority cause encoder: opcode > overflow > divzero.
    always_comb begin
        req_any_c  = exc_opcode | exc_overflow | exc_divzero;
        req_code_c = 2'b00;
        if (exc_opcode) begin
            req_code_c = 2'b01;
        end else if (exc_overflow) begin
            req_code_c = 2'b10;
        end else if (exc_divzero) begin
            req_code_c = 2'b11;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        pcv_d    = pcv_q;
        lost_d   = lost_q;
        iord_d   = 3'b000;
        epc_wr_d = 1'b0;
        pc_wr_d  = 1'b0;
        busy_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_any_c) begin
                    cause_d = req_code_c;
                    epc_d   = pc_current - PC_ADJUST;
                    cnt_d   = LAT_LOAD;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Counter holds the remaining FETCH cycles, including this one.
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_CAPTURE: begin
                pcv_d   = {24'b0, mem_rdata[7:0]};
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Requests are never queued while a sequence runs; just flag them.
        if ((state_q != S_IDLE) && req_any_c) begin
            lost_d = 1'b1;
        end

        // Outputs are registered, so they are decoded from the next state.
        if ((state_d == S_FETCH) || (state_d == S_CAPTURE)) begin
            iord_d = {1'b0, cause_d};
        end
        epc_wr_d = (state_q == S_IDLE) && (state_d == S_FETCH);
        pc_wr_d  = (state_d == S_COMMIT);
        busy_d   = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            cause_q  <= 2'b00;
            epc_q    <= '0;
            pcv_q    <= '0;
            iord_q   <= 3'b000;
            epc_wr_q <= 1'b0;
            pc_wr_q  <= 1'b0;
            busy_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            pcv_q    <= pcv_d;
            iord_q   <= iord_d;
            epc_wr_q <= epc_wr_d;
            pc_wr_q  <= pc_wr_d;
            busy_q   <= busy_d;
            lost_q   <= lost_d;
        end
    end

    assign iord_sel  = iord_q;
    assign epc_wr    = epc_wr_q;
    assign epc_value = epc_q;
    assign pc_wr     = pc_wr_q;
    assign pc_value  = pcv_q;
    assign cause     = cause_q;
    assign busy      = busy_q;
    assign exc_lost  = lost_q;

endmodule

// File: tb/tb_exc_vector_fetch.sv
// Testbench for exc_vector_fetch: two instances (MEM_LAT=2 and MEM_LAT=1)
// share the stimulus and are checked against a timeline model.
module tb_exc_vector_fetch;

    localparam int          LAT0   = 2;
    localparam int          LAT1   = 1;
    localparam logic [31:0] PC_ADJ = 32'd4;

    logic        clk;
    logic        reset;
    logic        exc_opcode, exc_overflow, exc_divzero;
    logic [31:0] pc_current, mem_rdata;

    logic [2:0]  iord_sel  [2];
    logic        epc_wr    [2];
    logic [31:0] epc_value [2];
    logic        pc_wr     [2];
    logic [31:0] pc_value  [2];
    logic [1:0]  cause     [2];
    logic        busy      [2];
    logic        exc_lost  [2];

    int n_vec = 0;
    int n_err = 0;

    // Model: position of each instance within its sequence (0 = idle,
    // n = cycle n after the sampling edge) plus the architectural values.
    int          lat     [2] = '{LAT0, LAT1};
    int          m_pos   [2];
    logic [1:0]  m_cause [2];
    logic [31:0] m_epc   [2];
    logic [31:0] m_pcv   [2];
    logic        m_lost  [2];

    exc_vector_fetch #(.MEM_LAT(LAT0), .PC_ADJUST(PC_ADJ)) u_dut0 (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
        .pc_current(pc_current), .mem_rdata(mem_rdata),
        .iord_sel(iord_sel[0]), .epc_wr(epc_wr[0]), .epc_value(epc_value[0]),
        .pc_wr(pc_wr[0]), .pc_value(pc_value[0]), .cause(cause[0]),
        .busy(busy[0]), .exc_lost(exc_lost[0])
    );

    exc_vector_fetch #(.MEM_LAT(LAT1), .PC_ADJUST(PC_ADJ)) u_dut1 (
        .clk(clk), .reset(reset),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_divzero(exc_divzero),
        .pc_current(pc_current), .mem_rdata(mem_rdata),
        .iord_sel(iord_sel[1]), .epc_wr(epc_wr[1]), .epc_value(epc_value[1]),
        .pc_wr(pc_wr[1]), .pc_value(pc_value[1]), .cause(cause[1]),
        .busy(busy[1]), .exc_lost(exc_lost[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] prio(input logic [2:0] req);
        if (req[2]) return 2'b01;
        if (req[1]) return 2'b10;
        if (req[0]) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k]   = 0;
            m_cause[k] = 2'b00;
            m_epc[k]   = 32'h0;
            m_pcv[k]   = 32'h0;
            m_lost[k]  = 1'b0;
        end
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_step(input logic [2:0] req, input logic [31:0] pc, input logic [31:0] rd);
        for (int k = 0; k < 2; k++) begin
            if (m_pos[k] == 0) begin
                if (req != 3'b000) begin
                    m_cause[k] = prio(req);
                    m_epc[k]   = pc - PC_ADJ;
                    m_pos[k]   = 1;
                end
            end else begin
                if (req != 3'b000) m_lost[k] = 1'b1;
                if (m_pos[k] == lat[k] + 1) m_pcv[k] = {24'h0, rd[7:0]};
                m_pos[k] = (m_pos[k] == lat[k] + 2) ? 0 : m_pos[k] + 1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int p;
            int l;
            p = m_pos[k];
            l = lat[k];
            chk($sformatf("d%0d_iord_sel", k), 32'(iord_sel[k]),
                (p >= 1 && p <= l + 1) ? 32'(m_cause[k]) : 32'h0);
            chk($sformatf("d%0d_epc_wr", k), 32'(epc_wr[k]), 32'(p == 1));
            chk($sformatf("d%0d_pc_wr", k), 32'(pc_wr[k]), 32'(p == l + 2));
            chk($sformatf("d%0d_busy", k), 32'(busy[k]), 32'(p != 0));
            chk($sformatf("d%0d_epc_value", k), epc_value[k], m_epc[k]);
            chk($sformatf("d%0d_pc_value", k), pc_value[k], m_pcv[k]);
            chk($sformatf("d%0d_cause", k), 32'(cause[k]), 32'(m_cause[k]));
            chk($sformatf("d%0d_exc_lost", k), 32'(exc_lost[k]), 32'(m_lost[k]));
        end
    endtask

    // Check the current cycle, then drive inputs for the coming edge.
    task automatic cycle(input logic [2:0] req, input logic [31:0] pc, input logic [31:0] rd);
        @(negedge clk);
        check_all();
        {exc_opcode, exc_overflow, exc_divzero} = req;
        pc_current = pc;
        mem_rdata  = rd;
        model_step(req, pc, rd);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic reset_mid();
        @(negedge clk);
        check_all();
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 reset = 1'b0;
        {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
        model_step(3'b000, pc_current, mem_rdata);
    endtask

    initial begin
        reset = 1'b1;
        {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
        pc_current = 32'h0;
        mem_rdata  = 32'h0;
        model_reset();

        @(negedge clk);
        check_all();
        reset = 1'b0;
        model_step(3'b000, 32'h0, 32'h0);

        // Overflow only
        cycle(3'b010, 32'h108, 32'h40);
        cycle(3'b000, 32'h108, 32'h40);
        chk("ovf_iord_c1", 32'(iord_sel[0]), 32'h2);
        chk("ovf_epc_c1", epc_value[0], 32'h104);
        repeat (3) cycle(3'b000, 32'h108, 32'h40);
        chk("ovf_pc_wr_c4", 32'(pc_wr[0]), 32'h1);
        chk("ovf_pc_value", pc_value[0], 32'h40);
        chk("ovf_cause", 32'(cause[0]), 32'h2);

        // All three requests together
        cycle(3'b111, 32'h200, 32'h55);
        cycle(3'b000, 32'h200, 32'h55);
        chk("all3_iord", 32'(iord_sel[0]), 32'h1);
        repeat (3) cycle(3'b000, 32'h200, 32'h55);
        chk("all3_cause", 32'(cause[0]), 32'h1);
        chk("all3_lost", 32'(exc_lost[0]), 32'h0);

        // Divzero with upper read-data bits set
        cycle(3'b001, 32'h300, 32'hABCDEF7F);
        cycle(3'b000, 32'h300, 32'hABCDEF7F);
        chk("dz_iord", 32'(iord_sel[0]), 32'h3);
        repeat (3) cycle(3'b000, 32'h300, 32'hABCDEF7F);
        chk("dz_pc_value", pc_value[0], 32'h7F);

        // Overflow, then divzero pulsed in cycle 2
        cycle(3'b010, 32'h400, 32'h11);
        cycle(3'b000, 32'h400, 32'h11);
        cycle(3'b001, 32'h400, 32'h11);
        cycle(3'b000, 32'h400, 32'h11);
        chk("lost_c3", 32'(exc_lost[0]), 32'h1);
        cycle(3'b000, 32'h400, 32'h11);
        chk("lost_cause", 32'(cause[0]), 32'h2);
        chk("lost_pc_value", pc_value[0], 32'h11);
        repeat (2) cycle(3'b000, 32'h400, 32'h11);
        chk("lost_sticky", 32'(exc_lost[0]), 32'h1);

        // Reset in cycle 2 of a sequence, then a clean sequence
        cycle(3'b010, 32'h500, 32'h22);
        cycle(3'b000, 32'h500, 32'h22);
        reset_mid();
        repeat (4) cycle(3'b000, 32'h500, 32'h22);
        cycle(3'b100, 32'h600, 32'h33);
        repeat (4) cycle(3'b000, 32'h600, 32'h33);
        chk("rst_next_pc_value", pc_value[0], 32'h33);
        chk("rst_next_cause", 32'(cause[0]), 32'h1);

        // MEM_LAT=1 instance, pc_current=0, request held high
        cycle(3'b010, 32'h0, 32'h0C);
        cycle(3'b010, 32'h0, 32'h0C);
        chk("lat1_epc", epc_value[1], 32'hFFFFFFFC);
        chk("lat1_busy_c1", 32'(busy[1]), 32'h1);
        cycle(3'b010, 32'h0, 32'h0C);
        cycle(3'b010, 32'h0, 32'h0C);
        chk("lat1_pc_wr_c3", 32'(pc_wr[1]), 32'h1);
        cycle(3'b010, 32'h0, 32'h0C);
        chk("lat1_busy_c4", 32'(busy[1]), 32'h0);
        cycle(3'b000, 32'h0, 32'h0C);
        chk("lat1_retrigger", 32'(busy[1]), 32'h1);
        repeat (6) cycle(3'b000, 32'h0, 32'h0C);
        reset_mid();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] req;
            if ($urandom_range(0, 99) == 0) begin
                reset_mid();
            end else begin
                req = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(1, 7)) : 3'b000;
                cycle(req, $urandom, $urandom);
            end
        end
        @(negedge clk);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
